// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the test-pattern pixel-stream source.
// Pattern codes, FSM encodings and pixel-stream protocol constants reused by scaler benches.
package video_pattern_gen_pkg;

  // Geometry and frame-counter widths
  localparam int unsigned DIM_W = 16;
  localparam int unsigned FC_W  = 8;

  // Pattern select codes
  localparam logic [1:0] PAT_HRAMP   = 2'd0;
  localparam logic [1:0] PAT_VRAMP   = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_DIAG    = 2'd3;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LINE   = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_VBLANK = 2'd3;

  // Pixel-stream protocol: de qualifies a pixel, hs marks the first pixel of a
  // line (only with de), vs marks the first pixel of a frame (only with de & hs).
  localparam int unsigned STREAM_CTRL_W = 3;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } stream_ctrl_t;

  // Configuration latched at each frame start
  typedef struct packed {
    logic [1:0]       pattern;
    logic [DIM_W-1:0] line_m1;
    logic [DIM_W-1:0] lines_m1;
    logic [DIM_W-1:0] hblank;
    logic [DIM_W-1:0] vblank;
  } pg_cfg_t;

  // Size minus one, with a size of 0 treated as 1
  function automatic logic [DIM_W-1:0] dim_m1(input logic [DIM_W-1:0] n);
    return (n == '0) ? '0 : n - DIM_W'(1);
  endfunction

endpackage

// File: rtl/video_pattern_gen_pattern_pixel.sv
// Registered pixel function: maps pattern, x, y and frame counter to a pixel value.
// Holds its output on cycles where no pixel is emitted.
module video_pattern_gen_pattern_pixel
  import video_pattern_gen_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = 12,
  parameter int unsigned CHECKER_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             pattern,
  input  logic [DIM_W-1:0]       x,
  input  logic [DIM_W-1:0]       y,
  input  logic [FC_W-1:0]        fc,
  input  logic                   border,
  output logic [PIXEL_WIDTH-1:0] pixel
);

  logic [PIXEL_WIDTH-1:0] pix_c;

  // Pattern evaluation; border forces all-ones
  always_comb begin
    pix_c = '0;
    case (pattern)
      PAT_HRAMP:   pix_c = PIXEL_WIDTH'(x);
      PAT_VRAMP:   pix_c = PIXEL_WIDTH'(y);
      PAT_CHECKER: pix_c = (x[CHECKER_LOG2] ^ y[CHECKER_LOG2]) ? '1 : '0;
      default:     pix_c = PIXEL_WIDTH'(x) + PIXEL_WIDTH'(y) + PIXEL_WIDTH'(fc);
    endcase
    if (border) pix_c = '1;
  end

  // Output register, updated only on emitted pixels
  always_ff @(posedge clk) begin
    if (rst) pixel <= '0;
    else if (en) pixel <= pix_c;
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern source for the scaler pixel stream (do/de/hs/vs).
// Optional macro PATTERN_GEN_BORDER_EN: force all-ones on the frame border pixels.
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH   = 12,
  parameter int unsigned SPARSE_OUTPUT = 2,
  parameter int unsigned CHECKER_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [1:0]             pattern_sel_i,
  input  logic [15:0]            line_size_i,
  input  logic [15:0]            frame_lines_i,
  input  logic [15:0]            hblank_i,
  input  logic [15:0]            vblank_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o
);

  localparam int unsigned SPARSE_W = (SPARSE_OUTPUT > 0) ? $clog2(SPARSE_OUTPUT + 1) : 1;
  localparam logic [SPARSE_W-1:0] SPARSE_LAST = SPARSE_W'(SPARSE_OUTPUT);

  logic [1:0]          state_q, state_d;
  logic [DIM_W-1:0]    x_q, x_d, y_q, y_d, blank_q, blank_d;
  logic [SPARSE_W-1:0] sparse_q, sparse_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic                busy_d;
  pg_cfg_t             cfg_q, cfg_in_c;
  stream_ctrl_t        ctrl_c;
  logic                cfg_load_c, emit_c, border_c;
  logic                line_end_c, hblank_done_c, vblank_done_c;

  // Configuration snapshot presented for latching at frame start
  always_comb begin
    cfg_in_c.pattern  = pattern_sel_i;
    cfg_in_c.line_m1  = dim_m1(line_size_i);
    cfg_in_c.lines_m1 = dim_m1(frame_lines_i);
    cfg_in_c.hblank   = hblank_i;
    cfg_in_c.vblank   = vblank_i;
  end

  // Next-state logic; zero-length blanking collapses straight through its state
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    sparse_d      = sparse_q;
    blank_d       = blank_q;
    fc_d          = fc_q;
    busy_d        = busy_o;
    cfg_load_c    = 1'b0;
    emit_c        = 1'b0;
    line_end_c    = 1'b0;
    hblank_done_c = 1'b0;
    vblank_done_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          cfg_load_c = 1'b1;
          x_d        = '0;
          y_d        = '0;
          sparse_d   = '0;
          blank_d    = '0;
          busy_d     = 1'b1;
          state_d    = ST_LINE;
        end
      end
      ST_LINE: begin
        emit_c = (sparse_q == '0);
        // x advances at the end of each cadence window so the trailing gap completes
        if (sparse_q == SPARSE_LAST) begin
          sparse_d = '0;
          if (x_q == cfg_q.line_m1) begin
            x_d        = '0;
            line_end_c = 1'b1;
          end else begin
            x_d = x_q + DIM_W'(1);
          end
        end else begin
          sparse_d = sparse_q + SPARSE_W'(1);
        end
      end
      ST_HBLANK: begin
        if (blank_q == cfg_q.hblank - DIM_W'(1)) hblank_done_c = 1'b1;
        else blank_d = blank_q + DIM_W'(1);
      end
      default: begin
        if (blank_q == cfg_q.vblank - DIM_W'(1)) vblank_done_c = 1'b1;
        else blank_d = blank_q + DIM_W'(1);
      end
    endcase

    if (line_end_c) begin
      if (cfg_q.hblank == '0) begin
        hblank_done_c = 1'b1;
      end else begin
        blank_d = '0;
        state_d = ST_HBLANK;
      end
    end

    if (hblank_done_c) begin
      blank_d = '0;
      if (y_q == cfg_q.lines_m1) begin
        if (cfg_q.vblank == '0) vblank_done_c = 1'b1;
        else state_d = ST_VBLANK;
      end else begin
        y_d     = y_q + DIM_W'(1);
        state_d = ST_LINE;
      end
    end

    if (vblank_done_c) begin
      blank_d  = '0;
      x_d      = '0;
      y_d      = '0;
      sparse_d = '0;
      fc_d     = fc_q + FC_W'(1);
      if (en_i) begin
        cfg_load_c = 1'b1;
        busy_d     = 1'b1;
        state_d    = ST_LINE;
      end else begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  // Stream control for the emitted pixel, aligned with the pixel register
  always_comb begin
    ctrl_c.de = emit_c;
    ctrl_c.hs = emit_c & (x_q == '0);
    ctrl_c.vs = emit_c & (x_q == '0) & (y_q == '0);
  end

`ifdef PATTERN_GEN_BORDER_EN
  // Border pixels override the pattern
  always_comb begin
    border_c = (x_q == '0) || (x_q == cfg_q.line_m1) ||
               (y_q == '0) || (y_q == cfg_q.lines_m1);
  end
`else
  // Pattern only
  always_comb begin
    border_c = 1'b0;
  end
`endif

  // State, counters, configuration and stream control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sparse_q <= '0;
      blank_q  <= '0;
      fc_q     <= '0;
      cfg_q    <= '0;
      busy_o   <= 1'b0;
      de_o     <= 1'b0;
      hs_o     <= 1'b0;
      vs_o     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sparse_q <= sparse_d;
      blank_q  <= blank_d;
      fc_q     <= fc_d;
      busy_o   <= busy_d;
      de_o     <= ctrl_c.de;
      hs_o     <= ctrl_c.hs;
      vs_o     <= ctrl_c.vs;
      if (cfg_load_c) cfg_q <= cfg_in_c;
    end
  end

  video_pattern_gen_pattern_pixel #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .CHECKER_LOG2 (CHECKER_LOG2)
  ) u_pixel (
    .clk     (clk),
    .rst     (rst),
    .en      (emit_c),
    .pattern (cfg_q.pattern),
    .x       (x_q),
    .y       (y_q),
    .fc      (fc_q),
    .border  (border_c),
    .pixel   (do_o)
  );

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: a sparse instance (SPARSE_OUTPUT=2) and a
// back-to-back instance (SPARSE_OUTPUT=0). Build with PATTERN_GEN_BORDER_EN for the border run.
module tb_video_pattern_gen;

  typedef struct {
    int         t;
    logic [11:0] px;
    logic       hs;
    logic       vs;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [1:0]  pat_a = 2'd0;
  logic [15:0] ls_a = 16'd1, fl_a = 16'd1, hb_a = 16'd0, vb_a = 16'd0;
  logic [11:0] do_a, do_b;
  logic        de_a, hs_a, vs_a, busy_a;
  logic        de_b, hs_b, vs_b, busy_b;

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    viol_a = 0, viol_b = 0;
  beat_t qa[$];
  beat_t qb[$];

  always #5 clk = ~clk;

  video_pattern_gen #(.PIXEL_WIDTH(12), .SPARSE_OUTPUT(2), .CHECKER_LOG2(3)) dut_a (
    .clk(clk), .rst(rst), .en_i(en_a), .pattern_sel_i(pat_a),
    .line_size_i(ls_a), .frame_lines_i(fl_a), .hblank_i(hb_a), .vblank_i(vb_a),
    .do_o(do_a), .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a), .busy_o(busy_a)
  );

  video_pattern_gen #(.PIXEL_WIDTH(12), .SPARSE_OUTPUT(0), .CHECKER_LOG2(3)) dut_b (
    .clk(clk), .rst(rst), .en_i(en_b), .pattern_sel_i(2'd3),
    .line_size_i(16'd1), .frame_lines_i(16'd1), .hblank_i(16'd0), .vblank_i(16'd0),
    .do_o(do_b), .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b), .busy_o(busy_b)
  );

  // Capture every valid pixel and count protocol violations, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (de_a) qa.push_back('{t: cyc, px: do_a, hs: hs_a, vs: vs_a});
    if (de_b) qb.push_back('{t: cyc, px: do_b, hs: hs_b, vs: vs_b});
    if ((hs_a && !de_a) || (vs_a && !hs_a)) viol_a++;
    if ((hs_b && !de_b) || (vs_b && !hs_b)) viol_b++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic start_a(input logic [1:0] pat, input int ls, input int fl,
                         input int hb, input int vb, input bit hold);
    pat_a = pat;
    ls_a  = 16'(ls);
    fl_a  = 16'(fl);
    hb_a  = 16'(hb);
    vb_a  = 16'(vb);
    qa.delete();
    en_a = 1'b1;
    @(negedge clk);
    check_eq("a_busy_start", int'(busy_a), 1);
    if (!hold) en_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (busy_a !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_idle_timeout", int'(busy_a), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_qa(input int count, input int budget);
    int n = 0;
    while (qa.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_pixel_timeout", int'(qa.size() >= count), 1);
  endtask

  initial begin
    int exp2[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    int exp4[12] = '{0, 1, 1, 2, 1, 2, 2, 3, 2, 3, 3, 4};
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_do", int'(do_a), 0);
    check_eq("rst_de", int'(de_a), 0);
    check_eq("rst_hs", int'(hs_a), 0);
    check_eq("rst_vs", int'(vs_a), 0);
    check_eq("rst_busy", int'(busy_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1x1 back-to-back frames: one pixel per cycle, fc visible through diagonal pattern
    en_b = 1'b1;
    n = 0;
    while (qb.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    en_b = 1'b0;
    n = 0;
    while (busy_b !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("b_idle_timeout", int'(busy_b), 0);
    check_eq("b_count", int'(qb.size() >= 4), 1);
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      check_eq($sformatf("b_hs[%0d]", i), int'(qb[i].hs), 1);
      check_eq($sformatf("b_vs[%0d]", i), int'(qb[i].vs), 1);
`ifndef PATTERN_GEN_BORDER_EN
      check_eq($sformatf("b_do[%0d]", i), int'(qb[i].px), i);
`endif
      if (i > 0) check_eq($sformatf("b_gap[%0d]", i), qb[i].t - qb[i-1].t, 1);
    end

    // Diagonal + frame counter over three frames from reset
    start_a(2'd3, 2, 2, 1, 2, 1'b1);
    wait_qa(9, 2000);
    en_a = 1'b0;
    wait_idle_a(2000);
    check_eq("diag_count", qa.size(), 12);
    for (int i = 0; i < 12 && i < qa.size(); i++) begin
      check_eq($sformatf("diag_vs[%0d]", i), int'(qa[i].vs), int'(i % 4 == 0));
`ifndef PATTERN_GEN_BORDER_EN
      check_eq($sformatf("diag_do[%0d]", i), int'(qa[i].px), exp4[i]);
`endif
    end

    // H ramp, 4x3, sparse cadence and blanking timing
    start_a(2'd0, 4, 3, 5, 7, 1'b0);
    wait_idle_a(2000);
    check_eq("hramp_count", qa.size(), 12);
    for (int i = 0; i < 12 && i < qa.size(); i++) begin
      check_eq($sformatf("hramp_hs[%0d]", i), int'(qa[i].hs), int'(i % 4 == 0));
      check_eq($sformatf("hramp_vs[%0d]", i), int'(qa[i].vs), int'(i == 0));
`ifndef PATTERN_GEN_BORDER_EN
      check_eq($sformatf("hramp_do[%0d]", i), int'(qa[i].px), i % 4);
`endif
      if (i > 0) check_eq($sformatf("hramp_gap[%0d]", i), qa[i].t - qa[i-1].t,
                          (i % 4 == 0) ? 8 : 3);
    end

`ifndef PATTERN_GEN_BORDER_EN
    // V ramp, 2x4
    start_a(2'd1, 2, 4, 1, 1, 1'b0);
    wait_idle_a(2000);
    check_eq("vramp_count", qa.size(), 8);
    for (int i = 0; i < 8 && i < qa.size(); i++)
      check_eq($sformatf("vramp_do[%0d]", i), int'(qa[i].px), exp2[i]);

    // Checker, 16x9: rows 0 and 8 straddle the square boundary
    start_a(2'd2, 16, 9, 0, 0, 1'b0);
    wait_idle_a(5000);
    check_eq("checker_count", qa.size(), 144);
    for (int x = 0; x < 16 && qa.size() == 144; x++) begin
      check_eq($sformatf("checker_r0[%0d]", x), int'(qa[x].px), (x < 8) ? 0 : 4095);
      check_eq($sformatf("checker_r8[%0d]", x), int'(qa[128 + x].px), (x < 8) ? 4095 : 0);
    end
`else
    // Border override, 4x4 V ramp
    start_a(2'd1, 4, 4, 1, 1, 1'b0);
    wait_idle_a(2000);
    check_eq("border_count", qa.size(), 16);
    for (int i = 0; i < 16 && qa.size() == 16; i++)
      check_eq($sformatf("border_do[%0d]", i), int'(qa[i].px),
               ((i / 4 == 0) || (i / 4 == 3) || (i % 4 == 0) || (i % 4 == 3)) ? 4095 : i / 4);
`endif

    // Reset mid-line, then restart
    start_a(2'd0, 8, 2, 2, 2, 1'b0);
    wait_qa(2, 500);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_de", int'(de_a), 0);
    check_eq("midrst_hs", int'(hs_a), 0);
    check_eq("midrst_vs", int'(vs_a), 0);
    check_eq("midrst_do", int'(do_a), 0);
    check_eq("midrst_busy", int'(busy_a), 0);
    @(negedge clk);
    rst = 1'b0;
    start_a(2'd0, 8, 2, 2, 2, 1'b0);
    wait_qa(1, 500);
    if (qa.size() > 0) begin
      check_eq("restart_vs", int'(qa[0].vs), 1);
      check_eq("restart_hs", int'(qa[0].hs), 1);
    end
    wait_idle_a(2000);
    check_eq("restart_count", qa.size(), 16);

    check_eq("proto_a", viol_a, 0);
    check_eq("proto_b", viol_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Source for the pixel stream protocol consumed by the scaler blocks: di/de/hs/vs, with de qualifying each pixel, hs marking the first pixel of a line and vs marking the first pixel of a frame.
- Emits configurable-size test frames, with programmable sparse cadence and horizontal/vertical blanking.
- Drives scaler inputs in bring-up and simulation, or stands in for a camera.

Parameters:
- PIXEL_WIDTH, 12, pixel bit width.
- SPARSE_OUTPUT, 2, idle cycles inserted after every pixel (0 = back-to-back).
- CHECKER_LOG2, 3, checker square size is 2^CHECKER_LOG2 pixels.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  run enable; sampled only at frame boundary.
- pattern_sel_i  in  2  0 = H ramp, 1 = V ramp, 2 = checker, 3 = diagonal + frame counter.
- line_size_i  in  16  pixels per line; 0 treated as 1.
- frame_lines_i  in  16  lines per frame; 0 treated as 1.
- hblank_i  in  16  idle cycles after each line.
- vblank_i  in  16  idle cycles after each frame.
- do_o  out  PIXEL_WIDTH  pixel value.
- de_o  out  1  pixel valid.
- hs_o  out  1  first pixel of line; only asserted with de_o.
- vs_o  out  1  first pixel of frame; only asserted with de_o and hs_o.
- busy_o  out  1  high while a frame is in progress.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; x, y, sparse and blank counters 0; frame counter 0.
- All outputs are registered. Pixel value, de_o, hs_o and vs_o are cycle-aligned.
- FSM states IDLE, LINE, HBLANK, VBLANK:
  - IDLE: when en_i = 1, latch all configuration inputs, reset x/y, set busy_o, go to LINE next cycle. Configuration changes mid-frame are ignored.
  - LINE: a sparse counter runs 0..SPARSE_OUTPUT. When it is 0, emit a pixel: de_o = 1, x increments. Other cycles: de_o = 0, do_o holds. After pixel x = line_size-1 is emitted, go to HBLANK at the next cadence point (trailing sparse gap is completed first).
  - HBLANK: count hblank cycles; 0 means zero cycles. Then y increments. If y was frame_lines-1, go to VBLANK; else go to LINE with x = 0.
  - VBLANK: count vblank cycles. Then increment the frame counter (wraps at 2^8) and clear busy_o. If en_i = 1, relatch configuration and go straight to LINE; else go to IDLE.
- hs_o = de_o & (x == 0). vs_o = de_o & (x == 0) & (y == 0).
- Pixel value is a function of the latched pattern, x, y and frame counter (fc), truncated to PIXEL_WIDTH:
  - Pattern 0: x.
  - Pattern 1: y.
  - Pattern 2: all-ones if x[CHECKER_LOG2] ^ y[CHECKER_LOG2], else 0.
  - Pattern 3: x + y + fc, modulo 2^PIXEL_WIDTH.
- Minimum frame of 1x1 pixel: a single cycle with de_o, hs_o and vs_o all high.
- rst mid-frame: outputs drop to 0 on the next edge. No partial-line completion.
- en_i deasserted mid-frame: current frame completes, including VBLANK.

Optional Feature:
- Macro PATTERN_GEN_BORDER_EN.
- When defined, pixels with x == 0, x == line_size-1, y == 0 or y == frame_lines-1 output all-ones, overriding the pattern. Used to check scaler edge handling.
- When undefined, pattern only; no extra logic.

Decomposition:
- Shared package/include holds:
  - pattern codes PAT_HRAMP = 0, PAT_VRAMP = 1, PAT_CHECKER = 2, PAT_DIAG = 3;
  - FSM state encodings;
  - the stream protocol description constants reused by scaler benches.
- One natural sub-module, pattern_pixel: registered pixel function taking pattern, x, y and fc.
  - The FSM pipelines de/hs/vs by one cycle to match its single-cycle latency.

Test Plan:
- line 4, lines 3, SPARSE 2, hblank 5, vblank 7, pattern 0:
  - de pulses every 3rd cycle; do sequence 0,1,2,3 per line;
  - 12 de pulses per frame; 3 hs pulses; 1 vs pulse coincident with the first hs.
- Pattern 1, line 2, lines 4: do = 0,0,1,1,2,2,3,3.
- Pattern 2, CHECKER_LOG2 = 3, line 16: x 0-7 → 0, x 8-15 → 4095 on row 0; inverted on row 8.
- Pattern 3 over two frames: first pixel of frame 1 = 1, of frame 2 = 2.
- line 1, lines 1, hblank 0, vblank 0, SPARSE 0: de/hs/vs high on consecutive-frame pixels with no gaps beyond the FSM overhead.
- Reset asserted mid-line:
  - next cycle de_o = hs_o = vs_o = 0 and do_o = 0;
  - after release with en_i = 1, the first pixel carries vs_o = 1.
- Border build (PATTERN_GEN_BORDER_EN), 4x4 frame, pattern 1: rows 0 and 3 all 4095; rows 1-2 read 4095, y, y, 4095.
